// File: rtl/sha256_block_feeder_pkg.sv
// Shared constants and FSM encoding for the SHA-256 block feeder and its word buffer.
package sha256_block_feeder_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned BLOCK_WORDS  = 16;
    localparam int unsigned DIGEST_WORDS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StLaunch,
        StFeed,
        StWaitd,
        StDrain
    } feeder_state_e;

endpackage

// File: rtl/sha256_word_buffer.sv
// 16x32 message block register file: one synchronous write port, one combinational read port.
module sha256_word_buffer
    import sha256_block_feeder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [3:0]        rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_q [BLOCK_WORDS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sha256_block_feeder.sv
// Host-side SHA-256 initiator: buffers message words into blocks, launches and feeds each
// block to the core, then captures the digest window and re-emits it as a stream.
module sha256_block_feeder #(
    parameter int unsigned FEED_GAP     = 1,
    parameter int unsigned DIGEST_WORDS = sha256_block_feeder_pkg::DIGEST_WORDS
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [sha256_block_feeder_pkg::WORD_W-1:0] in_data,
    input  logic                                       in_last,
    output logic                                       core_first,
    output logic                                       core_last,
    output logic [sha256_block_feeder_pkg::WORD_W-1:0] core_data,
    input  logic                                       core_busy,
    input  logic                                       core_oe,
    input  logic [sha256_block_feeder_pkg::WORD_W-1:0] core_digest,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [sha256_block_feeder_pkg::WORD_W-1:0] out_data,
    output logic                                       out_last
);

    import sha256_block_feeder_pkg::*;

    // The output stream is always 8 words; DIGEST_WORDS only limits how many are captured.
    localparam int unsigned DIG_SLOTS = sha256_block_feeder_pkg::DIGEST_WORDS;
    localparam logic [4:0]  FEED_END  = 5'(FEED_GAP + BLOCK_WORDS - 1);
    localparam logic [2:0]  DIG_LAST  = 3'(DIGEST_WORDS - 1);

    feeder_state_e state_q, state_d;

    logic [3:0]        wcnt_q, wcnt_d;
    logic [4:0]        fcnt_q, fcnt_d;
    logic [2:0]        dcnt_q, dcnt_d;
    logic [2:0]        rcnt_q, rcnt_d;
    logic              first_pending_q, first_pending_d;
    logic              last_pending_q, last_pending_d;
    logic              err_q, err_d;
    logic              cap_q, cap_d;
    logic              core_oe_q;
    logic [WORD_W-1:0] dig_q [DIG_SLOTS];
    logic [WORD_W-1:0] dig_d [DIG_SLOTS];

    logic              buf_we;
    logic              feeding;
    logic [3:0]        feed_idx;
    logic [WORD_W-1:0] buf_rdata;

    assign feed_idx = 4'(fcnt_q - 5'(FEED_GAP));

    sha256_word_buffer u_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (buf_we),
        .wr_addr (wcnt_q),
        .wr_data (in_data),
        .rd_addr (feed_idx),
        .rd_data (buf_rdata)
    );

    always_comb begin
        state_d         = state_q;
        wcnt_d          = wcnt_q;
        fcnt_d          = fcnt_q;
        dcnt_d          = dcnt_q;
        rcnt_d          = rcnt_q;
        first_pending_d = first_pending_q;
        last_pending_d  = last_pending_q;
        err_d           = err_q;
        cap_d           = cap_q;
        dig_d           = dig_q;
        buf_we          = 1'b0;
        feeding         = 1'b0;
        in_ready        = 1'b0;
        core_first      = 1'b0;
        core_last       = 1'b0;
        out_valid       = 1'b0;
        out_last        = 1'b0;
        out_data        = '0;

        unique case (state_q)
            StIdle: begin
                first_pending_d = 1'b1;
                state_d         = StFill;
            end
            StFill: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_we = 1'b1;
                    // A short last block is an error but is still launched as the final block.
                    if (wcnt_q == 4'd15 || in_last) begin
                        if (wcnt_q != 4'd15) begin
                            err_d = 1'b1;
                        end
                        wcnt_d         = '0;
                        last_pending_d = in_last;
                        state_d        = StLaunch;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
            end
            StLaunch: begin
                if (!core_busy) begin
                    core_first      = first_pending_q;
                    core_last       = last_pending_q;
                    first_pending_d = 1'b0;
                    fcnt_d          = '0;
                    state_d         = StFeed;
                end
            end
            StFeed: begin
                feeding = (fcnt_q >= 5'(FEED_GAP));
                if (fcnt_q == FEED_END) begin
                    fcnt_d = '0;
                    if (last_pending_q) begin
                        dcnt_d  = '0;
                        cap_d   = 1'b0;
                        state_d = StWaitd;
                        for (int i = 0; i < DIG_SLOTS; i++) begin
                            dig_d[i] = '0;
                        end
                    end else begin
                        state_d = StFill;
                    end
                end else begin
                    fcnt_d = fcnt_q + 5'd1;
                end
            end
            StWaitd: begin
                // Capture starts only on a rising core_oe so a stale window is never reused.
                if (core_oe && (cap_q || !core_oe_q)) begin
                    dig_d[dcnt_q] = core_digest;
                    cap_d         = 1'b1;
                    if (dcnt_q == DIG_LAST) begin
                        dcnt_d  = '0;
                        cap_d   = 1'b0;
                        state_d = StDrain;
                    end else begin
                        dcnt_d = dcnt_q + 3'd1;
                    end
                end else if (cap_q && !core_oe) begin
                    err_d   = 1'b1;
                    dcnt_d  = '0;
                    cap_d   = 1'b0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                out_valid = 1'b1;
                out_data  = dig_q[rcnt_q];
                out_last  = (rcnt_q == 3'd7);
                if (out_ready) begin
                    if (rcnt_q == 3'd7) begin
                        rcnt_d          = '0;
                        first_pending_d = 1'b1;
                        state_d         = StIdle;
                    end else begin
                        rcnt_d = rcnt_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        core_data = feeding ? buf_rdata : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            wcnt_q          <= '0;
            fcnt_q          <= '0;
            dcnt_q          <= '0;
            rcnt_q          <= '0;
            first_pending_q <= 1'b0;
            last_pending_q  <= 1'b0;
            err_q           <= 1'b0;
            cap_q           <= 1'b0;
            core_oe_q       <= 1'b0;
            for (int i = 0; i < DIG_SLOTS; i++) begin
                dig_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            wcnt_q          <= wcnt_d;
            fcnt_q          <= fcnt_d;
            dcnt_q          <= dcnt_d;
            rcnt_q          <= rcnt_d;
            first_pending_q <= first_pending_d;
            last_pending_q  <= last_pending_d;
            err_q           <= err_d;
            cap_q           <= cap_d;
            core_oe_q       <= core_oe;
            dig_q           <= dig_d;
        end
    end

endmodule
